mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  - Memory-access stage, directly upstream of the MEM/WB pipeline register; consumes EX/MEM outputs.
//  - Performs loads and stores byte-serially over the shared 8-bit RAM port, which is arbitrated by mem_grant.
//  - Holds the pipeline with stall_req until the access completes.
//  - Drives write_o/regw_addr_o/regw_data_o into MEM/WB.
//  - Non-memory instructions pass through combinationally with zero latency.
// PARAMETERS
//  - RAM_ADDR_W  17  width of ram_addr; the effective address is truncated to its low RAM_ADDR_W bits
// PORTS
//  - clock          in   1    single clock; all state updates on posedge
//  - reset          in   1    synchronous, active-high
//  - write_i        in   1    EX/MEM: register write enable
//  - regw_addr_i    in   5    EX/MEM: destination register (`RegAddrBus)
//  - regw_data_i    in   32   EX/MEM: ALU result (`RegBus)
//  - mem_op_i       in   4    0=NOP 1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW; 9..15 are treated as NOP
//  - mem_addr_i     in   32   effective address
//  - mem_wdata_i    in   32   store data
//  - mem_grant      in   1    arbiter grant; the RAM port is usable this cycle
//  - ram_din        in   8    RAM read data, valid 1 cycle after the address is issued
//  - ram_addr       out  RAM_ADDR_W  RAM byte address
//  - ram_dout       out  8    RAM write data
//  - ram_wr         out  1    1=write, 0=read
//  - mem_req        out  1    requests the RAM port from the arbiter
//  - stall_req      out  1    freezes PC/IF/ID/EX and EX/MEM
//  - write_o        out  1    to MEM/WB
//  - regw_addr_o    out  5    to MEM/WB
//  - regw_data_o    out  32   to MEM/WB
// BEHAVIOUR
//  - EX/MEM inputs are held stable by the pipeline while stall_req=1; the block does not re-latch them.
//  - nbytes = 1 (B/BU), 2 (H/HU), 4 (W).
//  - Little-endian: byte k goes to/from addr+k. Address arithmetic wraps modulo 2^RAM_ADDR_W.
//  - Misaligned addresses are legal.
//  - FSM states: IDLE, BUSY, DRAIN, FINISH. Reset enters IDLE and clears cnt, buf, and the issued flag.
//  - IDLE:
//    - NOP: outputs = inputs, stall_req=0, mem_req=0.
//    - Load/store: stall_req=1, cnt<=0, next state BUSY.
//  - BUSY:
//    - mem_req=1, stall_req=1.
//    - When mem_grant=1: ram_addr=addr+cnt, cnt<=cnt+1.
//    - Stores: ram_wr=1, ram_dout=wdata[8cnt+7:8cnt].
//    - Loads: ram_wr=0, and the issued flag is set for the next cycle.
//    - When mem_grant=0: ram_wr=0, no issue, cnt holds. The issued flag still clears, so no bogus byte capture.
//    - Last byte issued (cnt==nbytes-1 with grant): store goes to FINISH; load goes to DRAIN.
//  - Load capture: on the cycle after an issue, buf byte slot <= ram_din. This occurs in BUSY or DRAIN.
//  - DRAIN: stall_req=1, mem_req=0. Captures the final byte, then goes to FINISH.
//  - FINISH:
//    - stall_req=0, mem_req=0, ram_wr=0; next state IDLE.
//    - Load: write_o=write_i, regw_data_o = buf sign- or zero-extended per op.
//    - Store: write_o=0.
//  - While stall_req=1: write_o=0 and regw_addr_o=0, so a bubble goes to MEM/WB.
//  - Latency with continuous grant: stall high for nbytes+1 cycles on stores and nbytes+2 on loads. The result appears in the FINISH cycle.
//  - Reset mid-access aborts immediately. During the reset cycle: ram_wr=0, mem_req=0, stall_req=0, write_o=0, regw_addr_o=0, regw_data_o=0.
//  - Outside reset, ram_addr and ram_dout are don't-care when ram_wr=0 and no issue is in progress.
// CONFIGURATION
//  - MEM_FWD_EN defined:
//    - Adds outputs fwd_write(1), fwd_addr(5), fwd_data(32) to ID for operand forwarding.
//    - They equal write_o/regw_addr_o/regw_data_o whenever stall_req=0, and are 0 otherwise.
//    - fwd_write is also 0 when regw_addr_o==0.
//  - MEM_FWD_EN undefined: these ports do not exist. ID relies on the MEM/WB path only.
// TESTING
//  1. NOP with write_i=1, addr=5, data=0x1234 -> same cycle write_o=1, addr 5, data 0x1234, stall_req=0.
//  2. SW 0xA1B2C3D4 to 0x100, grant=1 -> writes D4,C3,B2,A1 at 0x100..0x103 on consecutive cycles; stall_req high 5 cycles; write_o=0 at FINISH.
//  3. RAM[0x200..0x201]=0x80,0xFF:
//     - LH -> regw_data_o=0xFFFFFF80 at FINISH, stall_req high 4 cycles.
//     - LHU -> 0x0000FF80.
//  4. LW from 0x3FE with grant dropped for 2 cycles after byte 1 -> no capture or issue during the gap; correct word; stall lengthens by exactly 2.
//  5. Reset asserted in BUSY of an SW -> ram_wr=0 that cycle, FSM IDLE next cycle, and a following NOP passes through cleanly.
//  6. With MEM_FWD_EN defined, LB to x0 -> fwd_write=0 at FINISH; LB to x7 -> fwd_write=1, fwd_addr=7.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage over a shared 8-bit RAM port.
// Optional `MEM_FWD_EN adds fwd_write/fwd_addr/fwd_data outputs for ID.
module mem_stage #(
   parameter int RAM_ADDR_W = 17
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_i,
   input  logic [4:0]            regw_addr_i,
   input  logic [31:0]           regw_data_i,
   input  logic [3:0]            mem_op_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   input  logic                  mem_grant,
   input  logic [7:0]            ram_din,
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [7:0]            ram_dout,
   output logic                  ram_wr,
   output logic                  mem_req,
   output logic                  stall_req,
   output logic                  write_o,
   output logic [4:0]            regw_addr_o,
   output logic [31:0]           regw_data_o
`ifdef MEM_FWD_EN
   ,
   output logic                  fwd_write,
   output logic [4:0]            fwd_addr,
   output logic [31:0]           fwd_data
`endif
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN,
      FINISH
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [1:0]  cnt;
   logic [1:0]  cnt_n;
   logic        issued;
   logic        issued_n;
   logic [1:0]  slot;
   logic [1:0]  slot_n;
   logic [31:0] rd_buf;

   logic        is_load;
   logic        is_store;
   logic [1:0]  last_idx;
   logic [31:0] load_val;

   logic        unused_addr;
   assign unused_addr = ^mem_addr_i[31:RAM_ADDR_W];

   // Classify the operation and find the index of its final byte.
   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      last_idx = 2'd0;
      unique case (mem_op_i)
         OP_LB, OP_LBU: begin
            is_load  = 1'b1;
            last_idx = 2'd0;
         end
         OP_LH, OP_LHU: begin
            is_load  = 1'b1;
            last_idx = 2'd1;
         end
         OP_LW: begin
            is_load  = 1'b1;
            last_idx = 2'd3;
         end
         OP_SB: begin
            is_store = 1'b1;
            last_idx = 2'd0;
         end
         OP_SH: begin
            is_store = 1'b1;
            last_idx = 2'd1;
         end
         OP_SW: begin
            is_store = 1'b1;
            last_idx = 2'd3;
         end
         default: begin
            is_load  = 1'b0;
            is_store = 1'b0;
            last_idx = 2'd0;
         end
      endcase
   end

   // Sign- or zero-extend the assembled load bytes.
   always_comb begin
      load_val = rd_buf;
      unique case (mem_op_i)
         OP_LB:   load_val = {{24{rd_buf[7]}}, rd_buf[7:0]};
         OP_LH:   load_val = {{16{rd_buf[15]}}, rd_buf[15:0]};
         OP_LBU:  load_val = {24'd0, rd_buf[7:0]};
         OP_LHU:  load_val = {16'd0, rd_buf[15:0]};
         default: load_val = rd_buf;
      endcase
   end

   // State, byte counter and pending-capture bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 2'd0;
         issued <= 1'b0;
         slot   <= 2'd0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         issued <= issued_n;
         slot   <= slot_n;
      end
   end

   // Capture a read byte one cycle after its address was issued.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_buf <= 32'd0;
      end else if (issued) begin
         rd_buf[{slot, 3'b000} +: 8] <= ram_din;
      end
   end

   // Next-state logic and all stage outputs.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      issued_n    = 1'b0;
      slot_n      = slot;
      mem_req     = 1'b0;
      stall_req   = 1'b0;
      ram_wr      = 1'b0;
      write_o     = 1'b0;
      regw_addr_o = 5'd0;
      regw_data_o = 32'd0;
      ram_addr    = mem_addr_i[RAM_ADDR_W-1:0]
                  + RAM_ADDR_W'(cnt);
      ram_dout    = mem_wdata_i[{cnt, 3'b000} +: 8];

      unique case (state)
         IDLE: begin
            if (is_load || is_store) begin
               stall_req = 1'b1;
               cnt_n     = 2'd0;
               state_n   = BUSY;
            end else begin
               write_o     = write_i;
               regw_addr_o = regw_addr_i;
               regw_data_o = regw_data_i;
            end
         end
         BUSY: begin
            mem_req   = 1'b1;
            stall_req = 1'b1;
            if (!(is_load || is_store)) begin
               state_n = IDLE;
            end else if (mem_grant) begin
               ram_wr   = is_store;
               issued_n = is_load;
               slot_n   = cnt;
               cnt_n    = cnt + 2'd1;
               if (cnt == last_idx) begin
                  state_n = is_store ? FINISH : DRAIN;
               end
            end
         end
         DRAIN: begin
            stall_req = 1'b1;
            state_n   = FINISH;
         end
         FINISH: begin
            state_n     = IDLE;
            regw_addr_o = regw_addr_i;
            if (is_load) begin
               write_o     = write_i;
               regw_data_o = load_val;
            end else begin
               regw_data_o = regw_data_i;
            end
         end
         default: state_n = IDLE;
      endcase

      if (reset) begin
         ram_wr      = 1'b0;
         mem_req     = 1'b0;
         stall_req   = 1'b0;
         write_o     = 1'b0;
         regw_addr_o = 5'd0;
         regw_data_o = 32'd0;
      end
   end

`ifdef MEM_FWD_EN
   assign fwd_write = ~stall_req & write_o
                    & (regw_addr_o != 5'd0);
   assign fwd_addr  = stall_req ? 5'd0 : regw_addr_o;
   assign fwd_data  = stall_req ? 32'd0 : regw_data_o;
`endif

endmodule
